csr_unit: RTL and testbench
===========================

# csr_unit

Parametrised control/status register file for the 3-stage RV32 pipeline; successor to the single `tohost` register held inside the datapath. Implements all six Zicsr operations (CSRRW/S/C and immediate forms) over a configurable bank of scratch CSRs plus `tohost`, with optional 64-bit cycle/instret counters. Sits beside the execute stage: read data is returned combinationally for write-back selection, and writes commit at the clock edge that advances the instruction out of execute.

## Interface
- `XLEN`, 32, CSR data width (32 only for counter high-half mapping; scratch/tohost follow XLEN)
- `NUM_SCRATCH`, 4, number of read/write scratch CSRs, 1..16, mapped at 12'h340 + i
- `TOHOST_ADDR`, 12'h51E, address of `tohost`

- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `stall`  in  1  pipeline stall; freezes all commits and instret
- `csr_valid`  in  1  execute-stage instruction is a CSR op
- `csr_funct`  in  3  Zicsr funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- `csr_addr`  in  12  CSR address
- `csr_rs1_idx`  in  5  rs1 field / zimm of the instruction
- `csr_rs1_data`  in  XLEN  forwarded rs1 value
- `retire`  in  1  one instruction retires this cycle
- `csr_rd_data`  out  XLEN  old CSR value, to write-back
- `csr_illegal`  out  1  access faults; no state change
- `tohost`  out  XLEN  current `tohost` value
- `tohost_valid`  out  1  one-cycle pulse after a non-zero `tohost` write

## Operation
- Source operand S = `csr_rs1_data` for funct3[2]=0, else zero-extended `csr_rs1_idx`.
- New value: RW → S; RS → old | S; RC → old & ~S.
- Write-enable = `csr_valid` & ~`stall` & ~`csr_illegal` & (RW/RWI, or S-source field `csr_rs1_idx` ≠ 0).
- Read-before-write: `csr_rd_data` = value before this cycle's commit; 0 when `csr_valid`=0 or illegal.
- Illegal when `csr_valid` and: address unmapped; funct3 ∈ {000,100}; or write-enable would be set on a read-only address (counters). Read-only counters accessed with RS/RC and `csr_rs1_idx`=0 are legal reads.
- Address map: 12'h340..12'h340+NUM_SCRATCH-1 scratch (RW); `TOHOST_ADDR` (RW); counters per Configuration.
- `tohost_valid` asserts the cycle after any committed `tohost` write whose new value ≠ 0, for exactly one cycle.
- No state machine beyond commit registers; all state is scratch array, `tohost`, `tohost_valid` flop, counters.

## Timing
- Reset (`reset`=0, async): all scratch, `tohost`, counters → 0; `tohost_valid` → 0; `csr_rd_data` and `csr_illegal` combinational, 0 while `csr_valid`=0.
- Read latency 0 cycles; write visible to a read in the next cycle (back-to-back CSR ops to the same address see the first result, no forwarding needed).
- `stall`=1: no CSR commit, instret holds, `tohost_valid` still self-clears; cycle counter keeps counting.
- Reset asserted mid-stall or mid-commit: reset wins, state cleared immediately.
- Counter wrap: 64-bit wrap from all-ones to 0, no flag.

## Configuration
- `CSR_COUNTERS_EN` defined: 64-bit `cycle` (+1 every clock out of reset) and `instret` (+1 on `retire` & ~`stall`) present, read-only at 12'hC00/12'hC80 (cycle lo/hi) and 12'hC02/12'hC82 (instret lo/hi).
- Not defined: counters removed; those four addresses are unmapped and raise `csr_illegal`.

## Test plan
- Reset release, then CSRRW `TOHOST_ADDR` S=32'h1 → `csr_rd_data`=0, next cycle `tohost`=1, `tohost_valid`=1 for one cycle.
- CSRRW 12'h340 S=32'hF0F0_0000, then CSRRS rs1 data 32'h0000_00FF, then CSRRCI zimm 5'h0F → rd 0, F0F0_0000, F0F0_00FF; final 12'h340 = 32'hF0F0_00F0.
- CSRRS 12'h341 with `csr_rs1_idx`=0 after prior value 32'h55 → rd 32'h55, no write, `csr_illegal`=0; same with `stall`=1 on a CSRRW → value unchanged.
- Access 12'h340+NUM_SCRATCH and funct3=100 → `csr_illegal`=1, `csr_rd_data`=0, no state change.
- With `CSR_COUNTERS_EN`: 10 clocks after reset, 4 with `retire` (1 stalled) → cycle lo ≥ 10, instret lo = 3; CSRRW to 12'hC00 → illegal. Preload-free wrap: force cycle to 64'hFFFF_FFFF_FFFF_FFFF → next read 0.
- Without `CSR_COUNTERS_EN`: CSRRS 12'hC00 rs1=0 → `csr_illegal`=1.

Source files
------------

// File: rtl/csr_unit.sv
// rtl/csr_unit.sv - Zicsr register file: scratch CSRs, tohost, optional cycle/instret counters (CSR_COUNTERS_EN)
module csr_unit #(
    parameter int          XLEN        = 32,
    parameter int          NUM_SCRATCH = 4,
    parameter logic [11:0] TOHOST_ADDR = 12'h51E
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            csr_valid,
    input  logic [2:0]      csr_funct,
    input  logic [11:0]     csr_addr,
    input  logic [4:0]      csr_rs1_idx,
    input  logic [XLEN-1:0] csr_rs1_data,
    input  logic            retire,
    output logic [XLEN-1:0] csr_rd_data,
    output logic            csr_illegal,
    output logic [XLEN-1:0] tohost,
    output logic            tohost_valid
);

    localparam logic [11:0] SCRATCH_BASE = 12'h340;

    logic [XLEN-1:0] scratch_q [NUM_SCRATCH];
    logic [XLEN-1:0] tohost_q;
    logic            tohost_valid_q;

    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] src_val;
    logic [XLEN-1:0] new_val;
    logic            mapped;
    logic            is_tohost;
    logic            is_ro;
    logic            bad_funct;
    logic            wr_intent;
    logic            we;

`ifdef CSR_COUNTERS_EN
    logic [63:0] cycle_q;
    logic [63:0] instret_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

    // Operand selection: immediate forms use the zero-extended rs1 field.
    assign src_val   = csr_funct[2] ? {{(XLEN-5){1'b0}}, csr_rs1_idx} : csr_rs1_data;
    assign bad_funct = (csr_funct[1:0] == 2'b00);
    // Set/clear with rs1 field zero is a pure read and never writes.
    assign wr_intent = (csr_funct[1:0] == 2'b01) || (csr_rs1_idx != 5'd0);

    // Address decode and old-value read mux.
    always_comb begin
        old_val   = '0;
        mapped    = 1'b0;
        is_tohost = 1'b0;
        is_ro     = 1'b0;
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (csr_addr == SCRATCH_BASE + 12'(i)) begin
                mapped  = 1'b1;
                old_val = scratch_q[i];
            end
        end
        if (csr_addr == TOHOST_ADDR) begin
            mapped    = 1'b1;
            is_tohost = 1'b1;
            old_val   = tohost_q;
        end
`ifdef CSR_COUNTERS_EN
        case (csr_addr)
            12'hC00: begin mapped = 1'b1; is_ro = 1'b1; old_val = cycle_q[31:0];    end
            12'hC80: begin mapped = 1'b1; is_ro = 1'b1; old_val = cycle_q[63:32];   end
            12'hC02: begin mapped = 1'b1; is_ro = 1'b1; old_val = instret_q[31:0];  end
            12'hC82: begin mapped = 1'b1; is_ro = 1'b1; old_val = instret_q[63:32]; end
            default: ;
        endcase
`endif
    end

    // Fault check, write-enable and read-modify-write value.
    always_comb begin
        csr_illegal = csr_valid && (!mapped || bad_funct || (is_ro && wr_intent));
        we          = csr_valid && !stall && !csr_illegal && wr_intent;
        csr_rd_data = (csr_valid && !csr_illegal) ? old_val : '0;
        case (csr_funct[1:0])
            2'b01:   new_val = src_val;
            2'b10:   new_val = old_val | src_val;
            2'b11:   new_val = old_val & ~src_val;
            default: new_val = old_val;
        endcase
    end

    // Scratch bank commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (we && csr_addr == SCRATCH_BASE + 12'(i)) scratch_q[i] <= new_val;
            end
        end
    end

    // tohost commit; the valid pulse is recomputed every cycle so it self-clears.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tohost_q       <= '0;
            tohost_valid_q <= 1'b0;
        end else begin
            tohost_valid_q <= we && is_tohost && (new_val != '0);
            if (we && is_tohost) tohost_q <= new_val;
        end
    end

`ifdef CSR_COUNTERS_EN
    // Free-running cycle counter and stall-gated instret counter, both wrap silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            if (retire && !stall) instret_q <= instret_q + 64'd1;
        end
    end
`endif

    assign tohost       = tohost_q;
    assign tohost_valid = tohost_valid_q;

endmodule

// File: tb/tb_csr_unit.sv
// tb/tb_csr_unit.sv - directed scoreboard bench for csr_unit
module tb_csr_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        csr_valid;
    logic [2:0]  csr_funct;
    logic [11:0] csr_addr;
    logic [4:0]  csr_rs1_idx;
    logic [31:0] csr_rs1_data;
    logic        retire;
    logic [31:0] csr_rd_data;
    logic        csr_illegal;
    logic [31:0] tohost;
    logic        tohost_valid;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q [$];

    localparam logic [2:0] F_RW  = 3'b001, F_RS  = 3'b010, F_RC  = 3'b011;
    localparam logic [2:0] F_RWI = 3'b101, F_RSI = 3'b110, F_RCI = 3'b111;

    csr_unit dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .csr_valid    (csr_valid),
        .csr_funct    (csr_funct),
        .csr_addr     (csr_addr),
        .csr_rs1_idx  (csr_rs1_idx),
        .csr_rs1_data (csr_rs1_data),
        .retire       (retire),
        .csr_rd_data  (csr_rd_data),
        .csr_illegal  (csr_illegal),
        .tohost       (tohost),
        .tohost_valid (tohost_valid)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: observed %h, scoreboard empty", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic drive(input logic [2:0] f, input logic [11:0] a, input logic [4:0] idx,
                         input logic [31:0] d, input logic st);
        @(posedge clk);
        #1;
        csr_valid    = 1'b1;
        csr_funct    = f;
        csr_addr     = a;
        csr_rs1_idx  = idx;
        csr_rs1_data = d;
        stall        = st;
        retire       = 1'b0;
    endtask

    task automatic step_op(input string tag, input logic [2:0] f, input logic [11:0] a,
                           input logic [4:0] idx, input logic [31:0] d, input logic st,
                           input logic [31:0] exp_rd, input logic exp_ill);
        drive(f, a, idx, d, st);
        push(exp_rd);
        push({31'd0, exp_ill});
        @(negedge clk);
        chk({tag, "_rd"}, csr_rd_data);
        chk({tag, "_ill"}, {31'd0, csr_illegal});
    endtask

    task automatic idle(input logic st, input logic rt);
        @(posedge clk);
        #1;
        csr_valid = 1'b0;
        stall     = st;
        retire    = rt;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; csr_valid = 1'b0; csr_funct = 3'b000;
        csr_addr = 12'h000; csr_rs1_idx = 5'd0; csr_rs1_data = 32'd0; retire = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        push(32'd0); chk("rst_tohost", tohost);
        push(32'd0); chk("rst_tv", {31'd0, tohost_valid});
        push(32'd0); chk("rst_rd", csr_rd_data);
        push(32'd0); chk("rst_ill", {31'd0, csr_illegal});
        reset = 1'b1;

        // tohost write and one-cycle pulse
        step_op("th_w1", F_RW, 12'h51E, 5'd1, 32'h1, 1'b0, 32'h0, 1'b0);
        idle(1'b0, 1'b0);
        push(32'h1); chk("th_val", tohost);
        push(32'h1); chk("th_tv1", {31'd0, tohost_valid});
        idle(1'b0, 1'b0);
        push(32'h0); chk("th_tv0", {31'd0, tohost_valid});

        // RW / RS / RCI read-modify-write chain on 0x340
        step_op("rw340", F_RW,  12'h340, 5'd3,  32'hF0F0_0000, 1'b0, 32'h0,         1'b0);
        step_op("rs340", F_RS,  12'h340, 5'd5,  32'h0000_00FF, 1'b0, 32'hF0F0_0000, 1'b0);
        step_op("rci",   F_RCI, 12'h340, 5'h0F, 32'hFFFF_FFFF, 1'b0, 32'hF0F0_00FF, 1'b0);
        step_op("rd340", F_RS,  12'h340, 5'd0,  32'hFFFF_FFFF, 1'b0, 32'hF0F0_00F0, 1'b0);

        // rs1=0 set is a pure read; stalled write does not commit
        step_op("rw341", F_RW, 12'h341, 5'd2, 32'h55,        1'b0, 32'h0,  1'b0);
        step_op("rs0a",  F_RS, 12'h341, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'h55, 1'b0);
        step_op("rs0b",  F_RC, 12'h341, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'h55, 1'b0);
        step_op("stlw",  F_RW, 12'h341, 5'd2, 32'h1234,      1'b1, 32'h55, 1'b0);
        step_op("stlr",  F_RS, 12'h341, 5'd0, 32'h0,         1'b0, 32'h55, 1'b0);

        // Immediate set on last scratch entry
        step_op("rsi343", F_RSI, 12'h343, 5'h11, 32'hDEAD_BEEF, 1'b0, 32'h0,  1'b0);
        step_op("rwi343", F_RWI, 12'h343, 5'h02, 32'hDEAD_BEEF, 1'b0, 32'h11, 1'b0);

        // Illegal accesses leave state untouched
        step_op("unmap", F_RW, 12'h344, 5'd1, 32'hAAAA_AAAA, 1'b0, 32'h0, 1'b1);
        step_op("f100",  3'b100, 12'h340, 5'd1, 32'hAAAA_AAAA, 1'b0, 32'h0, 1'b1);
        step_op("f000",  3'b000, 12'h340, 5'd1, 32'hAAAA_AAAA, 1'b0, 32'h0, 1'b1);
        step_op("nochg", F_RS, 12'h340, 5'd0, 32'h0, 1'b0, 32'hF0F0_00F0, 1'b0);

        // Zero tohost write: committed, no pulse
        step_op("th_w0", F_RW, 12'h51E, 5'd1, 32'h0, 1'b0, 32'h1, 1'b0);
        idle(1'b0, 1'b0);
        push(32'h0); chk("th_zero", tohost);
        push(32'h0); chk("th_notv", {31'd0, tohost_valid});

`ifndef CSR_COUNTERS_EN
        step_op("cnt_off", F_RS, 12'hC00, 5'd0, 32'h0, 1'b0, 32'h0, 1'b1);
`endif

        // Async reset in the middle of a cycle clears state immediately
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        push(32'h0); chk("ar_tohost", tohost);
        @(negedge clk);
        reset = 1'b1;
        step_op("ar_340", F_RS, 12'h340, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);

`ifdef CSR_COUNTERS_EN
        // Counters: fresh reset, 4 retires with one stalled
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        idle(1'b0, 1'b1);
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b1);
        repeat (6) idle(1'b0, 1'b0);
        step_op("instret", F_RS, 12'hC02, 5'd0, 32'h0, 1'b0, 32'd3, 1'b0);
        drive(F_RS, 12'hC00, 5'd0, 32'h0, 1'b0);
        @(negedge clk);
        push(32'd1); chk("cycle_ge10", {31'd0, (csr_rd_data >= 32'd10)});
        step_op("ro_wr", F_RW, 12'hC00, 5'd1, 32'h5, 1'b0, 32'h0, 1'b1);
        idle(1'b0, 1'b0);
        @(negedge clk);
        force dut.cycle_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.cycle_q;
        step_op("wrap_lo", F_RS, 12'hC00, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
        step_op("wrap_hi", F_RS, 12'hC80, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0);
`endif

        idle(1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
